// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle control FSM for the 16-bit TSC cpu.
// Sequences IF/ID/EX/MEM/WB over several cycles. It drives the memory
// strobes with a ready handshake and decodes every datapath select and
// enable from the current state and the instruction register. It also
// keeps the retired-instruction count and the halt flag.
module mc_control_unit #(
   parameter int WORD_SIZE = 16,
   parameter int LINK_REG  = 2
) (
   input  logic                 Clk,
   input  logic                 Reset_N,
   input  logic [3:0]           opcode,
   input  logic [5:0]           func,
   input  logic                 inst_ready,
   input  logic                 data_ready,
   input  logic                 branch_cond,
   output logic                 inst_read,
   output logic                 data_read,
   output logic                 data_write,
   output logic                 ir_write,
   output logic                 pc_write,
   output logic                 pc_write_cond,
   output logic [1:0]           pc_src,
   output logic [3:0]           alu_op,
   output logic [1:0]           alu_src_b,
   output logic                 reg_write,
   output logic [1:0]           reg_dst,
   output logic [1:0]           wb_src,
   output logic                 output_en,
   output logic [WORD_SIZE-1:0] num_inst,
   output logic                 is_halted,
   output logic [2:0]           state
);

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   // reg_dst select value that routes the write to the link register
   localparam logic [1:0] REG_DST_LINK = 2'd2;

   state_t               state_q, state_d;
   logic [WORD_SIZE-1:0] num_inst_q, num_inst_d;
   logic                 is_halted_q, is_halted_d;
   logic                 retire;

   // The branch decision is applied by the datapath (pc_write_cond AND
   // branch_cond). LINK_REG is consumed by the register-file write mux.
   logic       unused_branch_cond;
   logic [1:0] unused_link_reg;
   assign unused_branch_cond = branch_cond;
   assign unused_link_reg    = 2'(LINK_REG);

   // Instruction classes decoded from the instruction register
   logic is_rtype, is_ralu, is_jpr, is_jrl, is_wwd, is_hlt;
   logic is_br, is_adi, is_ori, is_lhi, is_lwd, is_swd, is_jmp, is_jal;
   logic is_ialu, goes_ex;

   assign is_rtype = (opcode == 4'd15);
   assign is_ralu  = is_rtype && (func[5:3] == 3'b000);
   assign is_jpr   = is_rtype && (func == 6'd25);
   assign is_jrl   = is_rtype && (func == 6'd26);
   assign is_wwd   = is_rtype && (func == 6'd28);
   assign is_hlt   = is_rtype && (func == 6'd29);
   assign is_br    = (opcode[3:2] == 2'b00);
   assign is_adi   = (opcode == 4'd4);
   assign is_ori   = (opcode == 4'd5);
   assign is_lhi   = (opcode == 4'd6);
   assign is_lwd   = (opcode == 4'd7);
   assign is_swd   = (opcode == 4'd8);
   assign is_jmp   = (opcode == 4'd9);
   assign is_jal   = (opcode == 4'd10);
   assign is_ialu  = is_adi || is_ori || is_lhi;
   assign goes_ex  = is_ralu || is_ialu || is_lwd || is_swd || is_br ||
                     is_jpr || is_jrl || is_wwd;

   // Next-state sequencing; IF and MEM wait on their ready inputs
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IF: begin
            if (inst_ready) state_d = S_ID;
         end
         S_ID: begin
            if (is_hlt)       state_d = S_HALT;
            else if (is_jal)  state_d = S_WB;
            else if (goes_ex) state_d = S_EX;
            else              state_d = S_IF;
         end
         S_EX: begin
            if (is_ralu || is_ialu || is_jrl) state_d = S_WB;
            else if (is_lwd || is_swd)        state_d = S_MEM;
            else                              state_d = S_IF;
         end
         S_MEM: begin
            if (data_ready) state_d = is_lwd ? S_WB : S_IF;
         end
         S_WB:    state_d = S_IF;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IF;
      endcase
   end

   // Retirement: last state of an instruction hands back to IF, or HLT enters HALT
   always_comb begin
      retire = ((state_d == S_IF) && (state_q != S_IF)) ||
               ((state_d == S_HALT) && (state_q != S_HALT));
      num_inst_d  = retire ? (num_inst_q + WORD_SIZE'(1)) : num_inst_q;
      is_halted_d = is_halted_q || (state_d == S_HALT);
   end

   // State, retired count and halt flag registers
   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) begin
         state_q     <= S_IF;
         num_inst_q  <= '0;
         is_halted_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         num_inst_q  <= num_inst_d;
         is_halted_q <= is_halted_d;
      end
   end

   // Decoded strobes and selects; all forced inactive while reset is held
   always_comb begin
      inst_read     = 1'b0;
      data_read     = 1'b0;
      data_write    = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_src        = 2'd0;
      alu_op        = 4'd0;
      alu_src_b     = 2'd0;
      reg_write     = 1'b0;
      reg_dst       = 2'd0;
      wb_src        = 2'd0;
      output_en     = 1'b0;
      if (Reset_N) begin
         case (state_q)
            S_IF: begin
               inst_read = 1'b1;
               ir_write  = inst_ready;
            end
            S_ID: begin
               pc_write = !is_hlt;
               pc_src   = (is_jmp || is_jal) ? 2'd2 : 2'd0;
            end
            S_EX: begin
               if (is_ralu)                      alu_op = {1'b0, func[2:0]};
               else if (is_ori)                  alu_op = 4'd3;
               else if (is_lhi)                  alu_op = 4'd8;
               else if (is_br)                   alu_op = 4'd9 + opcode;
               if (is_adi || is_lwd || is_swd)   alu_src_b = 2'd1;
               else if (is_ori)                  alu_src_b = 2'd2;
               else if (is_lhi)                  alu_src_b = 2'd3;
               if (is_br) begin
                  pc_write_cond = 1'b1;
                  pc_src        = 2'd1;
               end
               if (is_jpr || is_jrl) begin
                  pc_write = 1'b1;
                  pc_src   = 2'd3;
               end
               output_en = is_wwd;
            end
            S_MEM: begin
               data_read  = is_lwd;
               data_write = is_swd;
            end
            S_WB: begin
               reg_write = 1'b1;
               if (is_jal || is_jrl) begin
                  reg_dst = REG_DST_LINK;
                  wb_src  = 2'd2;
               end else if (is_lwd) begin
                  wb_src  = 2'd1;
               end else if (is_ralu) begin
                  reg_dst = 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign num_inst  = num_inst_q;
   assign is_halted = is_halted_q;
   assign state     = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: a per-instruction behavioural model (phase list
// plus a descriptor of what each instruction asserts) is compared with the
// DUT every cycle, with literal expectations for the directed scenarios.
module tb_mc_control_unit;

   logic        Clk = 1'b0;
   logic        Reset_N = 1'b0;
   logic [3:0]  opcode = 4'd0;
   logic [5:0]  func = 6'd0;
   logic        inst_ready = 1'b0, data_ready = 1'b0, branch_cond = 1'b0;
   logic        inst_read, data_read, data_write, ir_write, pc_write, pc_write_cond;
   logic [1:0]  pc_src, alu_src_b, reg_dst, wb_src;
   logic [3:0]  alu_op;
   logic        reg_write, output_en, is_halted;
   logic [15:0] num_inst;
   logic [2:0]  state;

   always #10 Clk = ~Clk;

   mc_control_unit #(.WORD_SIZE(16), .LINK_REG(2)) dut (
      .Clk(Clk), .Reset_N(Reset_N), .opcode(opcode), .func(func),
      .inst_ready(inst_ready), .data_ready(data_ready), .branch_cond(branch_cond),
      .inst_read(inst_read), .data_read(data_read), .data_write(data_write),
      .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .pc_src(pc_src), .alu_op(alu_op), .alu_src_b(alu_src_b),
      .reg_write(reg_write), .reg_dst(reg_dst), .wb_src(wb_src),
      .output_en(output_en), .num_inst(num_inst), .is_halted(is_halted),
      .state(state)
   );

   int n_checks = 0;
   int n_errors = 0;

   // model state: current phase, remaining phases of the instruction
   int          m_phase;
   int          m_path[$];
   logic [15:0] m_num;
   logic        m_halt;
   logic [3:0]  pend_op;
   logic [5:0]  pend_fn;
   // descriptor of the instruction in flight
   logic       d_idpw, d_pwc, d_expw, d_rd, d_wr, d_oen;
   logic [1:0] d_idpcs, d_expcs, d_srcb, d_wbdst, d_wbsrc;
   logic [3:0] d_alu;

   // observations for the directed literal checks
   int          o_irw, o_dr, o_oen, o_pwc, o_rw, o_rw_state;
   int          o_id_pcs, o_ex_pcs, o_wb_dst, o_wb_src;
   logic [31:0] o_seq;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [19:0] dut_ctrl();
      return {inst_read, data_read, data_write, ir_write, pc_write, pc_write_cond,
              pc_src, alu_op, alu_src_b, reg_write, reg_dst, wb_src, output_en};
   endfunction

   task automatic decode_model(input logic [3:0] op, input logic [5:0] fn);
      logic r, ralu;
      r    = (op == 4'd15);
      ralu = r && (fn < 6'd8);
      d_idpw = 1; d_pwc = 0; d_expw = 0; d_rd = 0; d_wr = 0; d_oen = 0;
      d_idpcs = 0; d_expcs = 0; d_srcb = 0; d_wbdst = 0; d_wbsrc = 0; d_alu = 0;
      m_path.delete();
      m_path.push_back(1);
      if (ralu || op == 4 || op == 5 || op == 6) begin
         m_path.push_back(2); m_path.push_back(4);
         d_wbdst = ralu ? 2'd1 : 2'd0;
      end else if (op == 7) begin
         m_path.push_back(2); m_path.push_back(3); m_path.push_back(4);
         d_rd = 1; d_wbsrc = 1;
      end else if (op == 8) begin
         m_path.push_back(2); m_path.push_back(3);
         d_wr = 1;
      end else if (op < 4) begin
         m_path.push_back(2);
         d_pwc = 1; d_expcs = 1; d_alu = 4'(9 + op);
      end else if (op == 9) begin
         d_idpcs = 2;
      end else if (op == 10) begin
         m_path.push_back(4);
         d_idpcs = 2; d_wbdst = 2; d_wbsrc = 2;
      end else if (r && fn == 25) begin
         m_path.push_back(2);
         d_expw = 1; d_expcs = 3;
      end else if (r && fn == 26) begin
         m_path.push_back(2); m_path.push_back(4);
         d_expw = 1; d_expcs = 3; d_wbdst = 2; d_wbsrc = 2;
      end else if (r && fn == 28) begin
         m_path.push_back(2);
         d_oen = 1;
      end else if (r && fn == 29) begin
         m_path.push_back(5);
         d_idpw = 0;
      end
      if (ralu) d_alu = {1'b0, fn[2:0]};
      if (op == 5) begin d_alu = 3; d_srcb = 2; end
      if (op == 6) begin d_alu = 8; d_srcb = 3; end
      if (op == 4 || op == 7 || op == 8) d_srcb = 1;
   endtask

   function automatic logic [19:0] model_ctrl(input logic ir, input logic dr);
      logic ird, drd, dwr, irw, pw, pwc, rw, oen;
      logic [1:0] pcs, srcb, dst, wbs;
      logic [3:0] alu;
      ird = 0; drd = 0; dwr = 0; irw = 0; pw = 0; pwc = 0; rw = 0; oen = 0;
      pcs = 0; srcb = 0; dst = 0; wbs = 0; alu = 0;
      case (m_phase)
         0: begin ird = 1; irw = ir; end
         1: begin pw = d_idpw; pcs = d_idpcs; end
         2: begin alu = d_alu; srcb = d_srcb; pwc = d_pwc; pw = d_expw; pcs = d_expcs; oen = d_oen; end
         3: begin drd = d_rd; dwr = d_wr; end
         4: begin rw = 1; dst = d_wbdst; wbs = d_wbsrc; end
         default: ;
      endcase
      if (dr && 1'b0) drd = 0;
      return {ird, drd, dwr, irw, pw, pwc, pcs, alu, srcb, rw, dst, wbs, oen};
   endfunction

   task automatic model_reset();
      m_phase = 0; m_num = 0; m_halt = 0; m_path.delete();
   endtask

   // advance the model across one rising edge using this cycle's inputs
   task automatic advance(input logic ir, input logic dr);
      if (m_phase == 0) begin
         if (ir) begin
            decode_model(pend_op, pend_fn);
            opcode = pend_op;
            func   = pend_fn;
            m_phase = m_path.pop_front();
         end
      end else if (m_phase == 5 || (m_phase == 3 && !dr)) begin
         // waiting or halted
      end else if (m_path.size() == 0) begin
         m_phase = 0;
         m_num++;
      end else begin
         m_phase = m_path.pop_front();
         if (m_phase == 5) begin m_num++; m_halt = 1; end
      end
      if (m_phase == 0) begin
         opcode = 4'($urandom);
         func   = 6'($urandom);
      end
   endtask

   task automatic step(input logic ir, input logic dr, input logic bc);
      inst_ready = ir; data_ready = dr; branch_cond = bc;
      @(negedge Clk);
      check("ctrl", 32'(dut_ctrl()), 32'(model_ctrl(ir, dr)));
      check("state", 32'(state), 32'(m_phase));
      check("num_inst", 32'(num_inst), 32'(m_num));
      check("is_halted", 32'(is_halted), 32'(m_halt));
      if (ir_write) o_irw++;
      if (data_read) o_dr++;
      if (output_en) o_oen++;
      if (pc_write_cond) o_pwc++;
      if (reg_write) begin
         o_rw++; o_rw_state = 32'(state); o_wb_dst = 32'(reg_dst); o_wb_src = 32'(wb_src);
      end
      if (state == 3'd1) o_id_pcs = 32'(pc_src);
      if (state == 3'd2) o_ex_pcs = 32'(pc_src);
      o_seq = (o_seq << 4) | 32'(state);
      @(posedge Clk);
      #1;
      advance(ir, dr);
   endtask

   // one instruction: ird/drd = cycles of ready held low in IF/MEM
   task automatic run_inst(input logic [3:0] op, input logic [5:0] fn, input int ird,
                           input int drd, input logic bc, output int cyc);
      int iw, dw;
      logic ir, dr, fetched, done;
      pend_op = op; pend_fn = fn;
      o_irw = 0; o_dr = 0; o_oen = 0; o_pwc = 0; o_rw = 0; o_rw_state = -1;
      o_id_pcs = -1; o_ex_pcs = -1; o_wb_dst = -1; o_wb_src = -1; o_seq = 0;
      iw = 0; dw = 0; cyc = 0; fetched = 0; done = 0;
      while (!done && cyc < 200) begin
         ir = 1'($urandom); dr = 1'($urandom);
         if (m_phase == 0) begin ir = (iw >= ird); iw++; end
         if (m_phase == 3) begin dr = (dw >= drd); dw++; end
         step(ir, dr, bc);
         cyc++;
         if (m_phase != 0) fetched = 1;
         done = fetched && (m_phase == 0 || m_phase == 5);
      end
      if (!done) begin
         n_checks++; n_errors++;
         $display("FAIL timeout: instruction %0h/%0h did not complete in %0d cycles", op, fn, cyc);
      end
   endtask

   // asynchronous reset pulse between clock edges
   task automatic async_reset();
      #2 Reset_N = 1'b0;
      #1;
      check("rst_state", 32'(state), 32'd0);
      check("rst_num_inst", 32'(num_inst), 32'd0);
      check("rst_is_halted", 32'(is_halted), 32'd0);
      check("rst_ctrl", 32'(dut_ctrl()), 32'd0);
      #1 Reset_N = 1'b1;
      model_reset();
      inst_ready = 1'b0;
      #1;
      check("post_rst_inst_read", 32'(inst_read), 32'd1);
      check("post_rst_state", 32'(state), 32'd0);
   endtask

   initial begin
      int cyc;
      logic [15:0] base;
      logic [3:0] op;
      logic [5:0] fn;
      model_reset();
      decode_model(4'd11, 6'd0);
      #3;
      check("init_state", 32'(state), 32'd0);
      check("init_num_inst", 32'(num_inst), 32'd0);
      check("init_is_halted", 32'(is_halted), 32'd0);
      check("init_ctrl", 32'(dut_ctrl()), 32'd0);
      @(negedge Clk);
      Reset_N = 1'b1;
      @(posedge Clk);
      #1;

      // reset in the middle of a stalled LWD memory read
      pend_op = 4'd7; pend_fn = 6'd0;
      step(1, 0, 0);
      step(0, 0, 0);
      step(0, 0, 0);
      step(0, 0, 0);
      check("lwd_in_mem", 32'(state), 32'd3);
      check("lwd_mem_read", 32'(data_read), 32'd1);
      async_reset();

      // ADD with immediate ready
      run_inst(4'd15, 6'd0, 0, 0, 0, cyc);
      check("add_cycles", 32'(cyc), 32'd4);
      check("add_states", o_seq, 32'h0124);
      check("add_regwrite_cnt", 32'(o_rw), 32'd1);
      check("add_regwrite_state", 32'(o_rw_state), 32'd4);
      check("add_reg_dst", 32'(o_wb_dst), 32'd1);
      check("add_num_inst", 32'(num_inst), 32'd1);

      // LWD with data_ready low for two extra cycles
      run_inst(4'd7, 6'd0, 0, 2, 0, cyc);
      check("lwd_cycles", 32'(cyc), 32'd7);
      check("lwd_data_read_cnt", 32'(o_dr), 32'd3);
      check("lwd_wb_src", 32'(o_wb_src), 32'd1);
      check("lwd_ir_write_cnt", 32'(o_irw), 32'd1);

      // BEQ taken then BNE not taken
      base = num_inst;
      run_inst(4'd1, 6'd0, 0, 0, 1, cyc);
      check("beq_cycles", 32'(cyc), 32'd3);
      check("beq_pwc_cnt", 32'(o_pwc), 32'd1);
      check("beq_pc_src", 32'(o_ex_pcs), 32'd1);
      run_inst(4'd0, 6'd0, 0, 0, 0, cyc);
      check("bne_cycles", 32'(cyc), 32'd3);
      check("bne_pwc_cnt", 32'(o_pwc), 32'd1);
      check("bne_pc_src", 32'(o_ex_pcs), 32'd1);
      check("branch_num_inst", 32'(num_inst), 32'(base + 16'd2));

      // JAL then WWD
      base = num_inst;
      run_inst(4'd10, 6'd0, 1, 0, 0, cyc);
      check("jal_cycles", 32'(cyc), 32'd4);
      check("jal_id_pc_src", 32'(o_id_pcs), 32'd2);
      check("jal_reg_dst", 32'(o_wb_dst), 32'd2);
      check("jal_wb_src", 32'(o_wb_src), 32'd2);
      run_inst(4'd15, 6'd28, 0, 0, 0, cyc);
      check("wwd_cycles", 32'(cyc), 32'd3);
      check("wwd_output_en_cnt", 32'(o_oen), 32'd1);
      check("jal_wwd_num_inst", 32'(num_inst), 32'(base + 16'd2));

      // random instruction mix with random ready stalls and occasional resets
      for (int i = 0; i < 300; i++) begin
         op = 4'($urandom);
         fn = 6'($urandom);
         if (op == 4'd15) begin
            case ($urandom_range(0, 3))
               0: fn = 6'($urandom_range(0, 7));
               1: fn = 6'(25 + $urandom_range(0, 1));
               2: fn = 6'd28;
               default: ;
            endcase
            if (fn == 6'd29) fn = 6'd0;
         end
         run_inst(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), cyc);
         if ($urandom_range(0, 39) == 0) async_reset();
      end

      // HLT, then a halted stretch with inst_ready toggling
      base = num_inst;
      run_inst(4'd15, 6'd29, 2, 0, 0, cyc);
      check("hlt_cycles", 32'(cyc), 32'd4);
      check("hlt_state", 32'(state), 32'd5);
      check("hlt_is_halted", 32'(is_halted), 32'd1);
      check("hlt_num_inst", 32'(num_inst), 32'(base + 16'd1));
      for (int i = 0; i < 20; i++) step(1'(i % 2), 1'($urandom), 1'($urandom));
      check("halted_state", 32'(state), 32'd5);
      check("halted_num_inst", 32'(num_inst), 32'(base + 16'd1));
      check("halted_ctrl", 32'(dut_ctrl()), 32'd0);
      async_reset();
      check("unhalted", 32'(is_halted), 32'd0);
      run_inst(4'd4, 6'd0, 0, 0, 0, cyc);
      check("after_halt_num_inst", 32'(num_inst), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
